pingpong_counter_gen: RTL and testbench
=======================================

Name: pingpong_counter_gen

Overview:
Parametrised multi-mode bounded counter. It is the next generation of the team's 4-bit ping-pong counter, with generic width, programmable step, four operating modes and turn/wrap event pulses. Used as a sweep/sequence generator feeding the display and traffic-timing blocks. Single clock domain.

Parameters:
WIDTH, 8, bit width of OUT, MAX, MIN, STEP
BCNT_W, 8, width of BOUNCE_CNT (only used with PPC_BOUNCE_COUNT_EN)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous active-high reset
ENABLE  input  1  1 = advance this cycle; 0 = hold everything
FLIP  input  1  reverse direction this cycle (ping-pong mode only)
MODE  input  2  00 ping-pong, 01 up-wrap, 10 down-wrap, 11 hold
MAX  input  WIDTH  upper bound, inclusive
MIN  input  WIDTH  lower bound, inclusive
STEP  input  WIDTH  increment magnitude; 0 is treated as 1
OUT  output  WIDTH  registered count
DIRECTION  output  1  1 = counting up, 0 = counting down
TURN  output  1  one-cycle pulse, registered; set on a boundary reversal in ping-pong mode
WRAP  output  1  one-cycle pulse, registered; set on a wrap in modes 01/10
BOUNCE_CNT  output  BCNT_W  present only with PPC_BOUNCE_COUNT_EN

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: OUT = MIN if MIN < MAX, else 0. DIRECTION = 1, TURN = 0, WRAP = 0, BOUNCE_CNT = 0. RESET overrides ENABLE, FLIP and MODE; asserting it mid-sweep takes effect at the next edge.
- Latency: every output is registered, so an input change affects outputs one edge later.
- Hold: when ENABLE = 0, or MODE = 11, or MIN >= MAX (invalid range), OUT and DIRECTION hold and TURN = WRAP = 0.
- Width rules: all sums and differences are computed in WIDTH+1 bits; no silent overflow. Effective step s = (STEP == 0) ? 1 : STEP.
- Out-of-range (valid range, enabled, modes 00/01/10): OUT > MAX loads MAX; OUT < MIN loads MIN. DIRECTION is unchanged and no pulse is raised. This takes one cycle and replaces the normal step for that cycle.
- Ping-pong (00):
  - d' = DIRECTION ^ FLIP.
  - If d' = 1 and OUT == MAX: DIRECTION <= 0, OUT <= max(MAX - s, MIN), TURN = 1.
  - If d' = 0 and OUT == MIN: DIRECTION <= 1, OUT <= min(MIN + s, MAX), TURN = 1.
  - Otherwise: DIRECTION <= d'. For d' = 1, OUT <= min(OUT + s, MAX). For d' = 0, OUT <= max(OUT - s, MIN).
  - A FLIP-only reversal does not raise TURN.
- Up-wrap (01): DIRECTION <= 1; FLIP is ignored. If OUT == MAX: OUT <= MIN and WRAP = 1. Otherwise OUT <= min(OUT + s, MAX).
- Down-wrap (10): DIRECTION <= 0; FLIP is ignored. If OUT == MIN: OUT <= MAX and WRAP = 1. Otherwise OUT <= max(OUT - s, MIN).
- Bound changes mid-run: take effect on the next edge through the out-of-range rule. No restart.
- MODE changes mid-run: take effect on the next edge, starting from the current OUT.

Optional Feature:
- Macro: PPC_BOUNCE_COUNT_EN.
- Defined: BOUNCE_CNT port exists. It increments on every cycle where TURN or WRAP is set, saturates at all-ones, and clears on RESET.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=4, MIN=3, MAX=9, STEP=1, MODE=00, RESET pulse then ENABLE=1 -> OUT 3,4,...,9,8,7,...; TURN high on the 9->8 and 3->4 edges only.
2. OUT=6 counting up, FLIP=1 for one cycle -> OUT=5, DIRECTION=0, TURN=0. Then FLIP=1 at OUT=3 with DIRECTION=0 -> OUT=4, DIRECTION=1, TURN=0.
3. MIN=3, MAX=9, STEP=4, MODE=00 -> OUT 3,7,9,5,3,7; TURN set on 9->5 and 3->7.
4. MODE=01, MIN=2, MAX=5, STEP=2 -> OUT 2,4,5,2; WRAP on 5->2. Then MODE=10 -> OUT 2->5 with WRAP, then 5,3,2.
5. OUT=8, MAX lowered to 5 -> next OUT=5 with no pulse. Then MIN=6, MAX=5 (invalid) -> OUT holds 5. ENABLE=0 -> holds. RESET mid-run with MIN=6, MAX=5 -> OUT=0, DIRECTION=1.
6. With PPC_BOUNCE_COUNT_EN, BCNT_W=2, scenario 1 run for 5 turns -> BOUNCE_CNT 1,2,3,3,3; RESET -> 0.

Source files
------------

// File: rtl/pingpong_counter_gen_if.sv
// Bus bundle for pingpong_counter_gen: control/bounds in, count and event pulses out.
// BOUNCE_CNT exists only when PPC_BOUNCE_COUNT_EN is defined.
interface pingpong_counter_gen_if #(
   parameter int WIDTH  = 8,
   parameter int BCNT_W = 8
);
   logic             ENABLE;
   logic             FLIP;
   logic [1:0]       MODE;
   logic [WIDTH-1:0] MAX;
   logic [WIDTH-1:0] MIN;
   logic [WIDTH-1:0] STEP;
   logic [WIDTH-1:0] OUT;
   logic             DIRECTION;
   logic             TURN;
   logic             WRAP;
`ifdef PPC_BOUNCE_COUNT_EN
   logic [BCNT_W-1:0] BOUNCE_CNT;
`endif

   modport master (
      output ENABLE, FLIP, MODE, MAX, MIN, STEP,
`ifdef PPC_BOUNCE_COUNT_EN
      input  BOUNCE_CNT,
`endif
      input  OUT, DIRECTION, TURN, WRAP
   );

   modport slave (
      input  ENABLE, FLIP, MODE, MAX, MIN, STEP,
`ifdef PPC_BOUNCE_COUNT_EN
      output BOUNCE_CNT,
`endif
      output OUT, DIRECTION, TURN, WRAP
   );
endinterface

// File: rtl/pingpong_counter_gen.sv
// Multi-mode bounded counter: ping-pong, up-wrap, down-wrap, hold, with TURN/WRAP pulses.
// Optional saturating event counter on BOUNCE_CNT when PPC_BOUNCE_COUNT_EN is defined.
module pingpong_counter_gen #(
   parameter int WIDTH  = 8,
   parameter int BCNT_W = 8
) (
   input  logic                   CLK,
   input  logic                   RESET,
   pingpong_counter_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      MODE_PINGPONG = 2'b00,
      MODE_UPWRAP   = 2'b01,
      MODE_DNWRAP   = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_t;

   logic [WIDTH-1:0] r_out;
   logic             r_dir;
   logic             r_turn;
   logic             r_wrap;

   mode_t            w_mode;
   logic             w_valid;
   logic             w_dflip;
   logic [WIDTH:0]   w_s;
   logic [WIDTH:0]   w_up;
   logic [WIDTH:0]   w_dn_lim;
   logic [WIDTH-1:0] w_up_sat;
   logic [WIDTH-1:0] w_dn_sat;
   logic [WIDTH-1:0] w_out_nxt;
   logic             w_dir_nxt;
   logic             w_turn_nxt;
   logic             w_wrap_nxt;

   assign w_mode  = mode_t'(bus.MODE);
   assign w_valid = bus.MIN < bus.MAX;
   assign w_dflip = r_dir ^ bus.FLIP;
   assign w_s     = (bus.STEP == '0) ? (WIDTH+1)'(1) : {1'b0, bus.STEP};

   // One extra bit on the sums keeps OUT+s and MIN+s from wrapping before the clamp.
   assign w_up     = {1'b0, r_out} + w_s;
   assign w_dn_lim = {1'b0, bus.MIN} + w_s;
   assign w_up_sat = (w_up > {1'b0, bus.MAX}) ? bus.MAX : w_up[WIDTH-1:0];
   assign w_dn_sat = ({1'b0, r_out} < w_dn_lim) ? bus.MIN : (r_out - w_s[WIDTH-1:0]);

   always_comb begin
      w_out_nxt  = r_out;
      w_dir_nxt  = r_dir;
      w_turn_nxt = 1'b0;
      w_wrap_nxt = 1'b0;
      if (bus.ENABLE && (w_mode != MODE_HOLD) && w_valid) begin
         if (r_out > bus.MAX) begin
            w_out_nxt = bus.MAX;
         end else if (r_out < bus.MIN) begin
            w_out_nxt = bus.MIN;
         end else begin
            case (w_mode)
               MODE_PINGPONG: begin
                  // At a bound the step away from it equals the normal clamped step.
                  if (w_dflip && (r_out == bus.MAX)) begin
                     w_dir_nxt  = 1'b0;
                     w_out_nxt  = w_dn_sat;
                     w_turn_nxt = 1'b1;
                  end else if (!w_dflip && (r_out == bus.MIN)) begin
                     w_dir_nxt  = 1'b1;
                     w_out_nxt  = w_up_sat;
                     w_turn_nxt = 1'b1;
                  end else begin
                     w_dir_nxt = w_dflip;
                     w_out_nxt = w_dflip ? w_up_sat : w_dn_sat;
                  end
               end
               MODE_UPWRAP: begin
                  w_dir_nxt = 1'b1;
                  if (r_out == bus.MAX) begin
                     w_out_nxt  = bus.MIN;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_out_nxt = w_up_sat;
                  end
               end
               MODE_DNWRAP: begin
                  w_dir_nxt = 1'b0;
                  if (r_out == bus.MIN) begin
                     w_out_nxt  = bus.MAX;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_out_nxt = w_dn_sat;
                  end
               end
               default: begin
                  w_out_nxt = r_out;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_out  <= w_valid ? bus.MIN : '0;
         r_dir  <= 1'b1;
         r_turn <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_out  <= w_out_nxt;
         r_dir  <= w_dir_nxt;
         r_turn <= w_turn_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign bus.OUT       = r_out;
   assign bus.DIRECTION = r_dir;
   assign bus.TURN      = r_turn;
   assign bus.WRAP      = r_wrap;

`ifdef PPC_BOUNCE_COUNT_EN
   logic [BCNT_W-1:0] r_bcnt;

   // Counts on the same edge that raises TURN/WRAP, so the two update together.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_bcnt <= '0;
      end else if ((w_turn_nxt || w_wrap_nxt) && (r_bcnt != '1)) begin
         r_bcnt <= r_bcnt + BCNT_W'(1);
      end
   end

   assign bus.BOUNCE_CNT = r_bcnt;
`endif

endmodule

// File: tb/tb_pingpong_counter_gen.sv
// Scoreboard bench for pingpong_counter_gen at WIDTH=4, BCNT_W=2.
// BOUNCE_CNT checks are active only when PPC_BOUNCE_COUNT_EN is defined.
module tb_pingpong_counter_gen;

   logic CLK;
   logic RESET;
   int   n_run;
   int   n_fail;

   pingpong_counter_gen_if #(.WIDTH(4), .BCNT_W(2)) pif ();

   pingpong_counter_gen #(.WIDTH(4), .BCNT_W(2)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (pif.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst, en, flip;
      logic [1:0] mode;
      logic [3:0] mn, mx, st;
      logic [3:0] out;
      logic       dir, turn, wrap;
      int         bcnt;
   } row_t;

   typedef struct packed {
      logic [3:0] out;
      logic       dir, turn, wrap;
   } exp_t;

   exp_t sb[$];
   int   sbb[$];

   function automatic row_t r(logic rst, logic en, logic flip, logic [1:0] mode,
                              int mn, int mx, int st,
                              int out, logic dir, logic turn, logic wrap, int bcnt);
      row_t x;
      x.rst = rst; x.en = en; x.flip = flip; x.mode = mode;
      x.mn = 4'(mn); x.mx = 4'(mx); x.st = 4'(st);
      x.out = 4'(out); x.dir = dir; x.turn = turn; x.wrap = wrap;
      x.bcnt = bcnt;
      return x;
   endfunction

   // Drive one cycle of stimulus and push what the DUT must show after the edge.
   task automatic apply(input row_t x);
      RESET      = x.rst;
      pif.ENABLE = x.en;
      pif.FLIP   = x.flip;
      pif.MODE   = x.mode;
      pif.MIN    = x.mn;
      pif.MAX    = x.mx;
      pif.STEP   = x.st;
      sb.push_back({x.out, x.dir, x.turn, x.wrap});
      sbb.push_back(x.bcnt);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      rows.push_back(r(1,1,1,2'b11, 3,9,1, 3,1,0,0, 0));
      rows.push_back(r(1,1,0,2'b00, 6,5,1, 0,1,0,0, 0));
      rows.push_back(r(1,0,0,2'b00, 3,9,1, 3,1,0,0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL reset_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   task automatic test_pingpong();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      int   outs[14]  = '{4,5,6,7,8,9,8,7,6,5,4,3,4,5};
      bit   dirs[14]  = '{1,1,1,1,1,1,0,0,0,0,0,0,1,1};
      bit   turns[14] = '{0,0,0,0,0,0,1,0,0,0,0,0,1,0};
      int   bc;
      rows.push_back(r(1,1,0,2'b00, 3,9,1, 3,1,0,0, 0));
      bc = 0;
      for (int k = 0; k < 14; k++) begin
         if (turns[k]) bc++;
         rows.push_back(r(0,1,0,2'b00, 3,9,1, outs[k],dirs[k],turns[k],0, bc));
      end
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL pingpong[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL pingpong_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   task automatic test_flip();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      rows.push_back(r(1,1,0,2'b00, 3,9,1, 3,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 4,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 5,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 6,1,0,0, 0));
      rows.push_back(r(0,1,1,2'b00, 3,9,1, 5,0,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 4,0,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 3,0,0,0, 0));
      rows.push_back(r(0,1,1,2'b00, 3,9,1, 4,1,0,0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL flip[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL flip_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   task automatic test_step();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      rows.push_back(r(1,1,0,2'b00, 3,9,4, 3,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,4, 7,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,4, 9,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,4, 5,0,1,0, 1));
      rows.push_back(r(0,1,0,2'b00, 3,9,4, 3,0,0,0, 1));
      rows.push_back(r(0,1,0,2'b00, 3,9,4, 7,1,1,0, 2));
      rows.push_back(r(0,1,0,2'b00, 3,9,4, 9,1,0,0, 2));
      rows.push_back(r(0,1,0,2'b00, 3,9,0, 8,0,1,0, 3));
      rows.push_back(r(0,1,0,2'b00, 3,9,0, 7,0,0,0, 3));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL step[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL step_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   task automatic test_wrap();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      rows.push_back(r(1,1,0,2'b01, 2,5,2, 2,1,0,0, 0));
      rows.push_back(r(0,1,1,2'b01, 2,5,2, 4,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b01, 2,5,2, 5,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b01, 2,5,2, 2,1,0,1, 1));
      rows.push_back(r(0,1,0,2'b10, 2,5,2, 5,0,0,1, 2));
      rows.push_back(r(0,1,1,2'b10, 2,5,2, 3,0,0,0, 2));
      rows.push_back(r(0,1,0,2'b10, 2,5,2, 2,0,0,0, 2));
      rows.push_back(r(0,1,0,2'b10, 2,5,2, 5,0,0,1, 3));
      rows.push_back(r(0,0,0,2'b10, 2,5,2, 5,0,0,0, 3));
      rows.push_back(r(0,1,0,2'b00, 2,5,2, 3,0,0,0, 3));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL wrap_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   task automatic test_bounds();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      rows.push_back(r(1,1,0,2'b00, 3,9,1, 3,1,0,0, 0));
      for (int k = 4; k <= 8; k++)
         rows.push_back(r(0,1,0,2'b00, 3,9,1, k,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,5,1, 5,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 6,5,1, 5,1,0,0, 0));
      rows.push_back(r(0,1,1,2'b01, 6,5,1, 5,1,0,0, 0));
      rows.push_back(r(0,0,0,2'b00, 3,9,1, 5,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b11, 3,9,1, 5,1,0,0, 0));
      rows.push_back(r(1,1,0,2'b00, 6,5,1, 0,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 3,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,1, 4,1,0,0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL bounds[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL bounds_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   // Large steps push OUT+s past 2^WIDTH and exercise saturation of BOUNCE_CNT.
   task automatic test_back_to_back();
      row_t rows[$];
      exp_t e, got;
      int   eb;
      rows.push_back(r(1,1,0,2'b00, 3,9,15, 3,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,15, 9,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b00, 3,9,15, 3,0,1,0, 1));
      rows.push_back(r(0,1,0,2'b00, 3,9,15, 9,1,1,0, 2));
      rows.push_back(r(0,1,0,2'b00, 3,9,15, 3,0,1,0, 3));
      rows.push_back(r(0,1,0,2'b00, 3,9,15, 9,1,1,0, 3));
      rows.push_back(r(0,1,0,2'b00, 3,9,15, 3,0,1,0, 3));
      rows.push_back(r(1,1,0,2'b01, 0,15,15, 0,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b01, 0,15,15, 15,1,0,0, 0));
      rows.push_back(r(0,1,0,2'b01, 0,15,15, 0,1,0,1, 1));
      rows.push_back(r(0,1,0,2'b10, 0,15,15, 15,0,0,1, 2));
      rows.push_back(r(0,1,0,2'b10, 0,15,15, 0,0,0,0, 2));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = sb.pop_front(); eb = sbb.pop_front();
         got = {pif.OUT, pif.DIRECTION, pif.TURN, pif.WRAP};
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got out=%0d dir=%b turn=%b wrap=%b, expected out=%0d dir=%b turn=%b wrap=%b",
                     i, got.out, got.dir, got.turn, got.wrap, e.out, e.dir, e.turn, e.wrap);
         end
`ifdef PPC_BOUNCE_COUNT_EN
         n_run++;
         if (pif.BOUNCE_CNT !== 2'(eb)) begin
            n_fail++;
            $display("FAIL back_to_back_bcnt[%0d]: got %0d, expected %0d", i, pif.BOUNCE_CNT, eb);
         end
`endif
      end
   endtask

   initial begin
      n_run      = 0;
      n_fail     = 0;
      RESET      = 1'b1;
      pif.ENABLE = 1'b0;
      pif.FLIP   = 1'b0;
      pif.MODE   = 2'b00;
      pif.MIN    = 4'd3;
      pif.MAX    = 4'd9;
      pif.STEP   = 4'd1;
      #2;
      test_reset();
      test_pingpong();
      test_flip();
      test_step();
      test_wrap();
      test_bounds();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
